// File: rtl/burst_mem_pkg.sv
// Shared types and width helpers for the burst memory model.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StBurst = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned off_width(input int unsigned burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned latency);
    return (latency > 0) ? $clog2(latency + 1) : 1;
  endfunction

endpackage

// File: rtl/burst_mem_model_addr_gen.sv
// Line base / beat offset tracking for one burst, with wrap inside the line.
module burst_addr_gen #(
  parameter int unsigned IdxW      = 5,
  parameter int unsigned OffW      = 1,
  parameter int unsigned BurstLen  = 2,
  parameter bit          WrapFirst = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            adv_i,
  input  logic [IdxW-1:0] idx_i,
  output logic [IdxW-1:0] rd_idx_o,
  output logic [OffW-1:0] off_o,
  output logic            last_o
);

  localparam logic [OffW-1:0] OffMask  = OffW'(BurstLen - 1);
  localparam logic [IdxW-1:0] BaseMask = ~IdxW'(BurstLen - 1);

  logic [IdxW-1:0] base_q, base_d;
  logic [OffW-1:0] off_q, off_d;
  logic [OffW-1:0] beat_q, beat_d;

  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    beat_d = beat_q;
    if (start_i) begin
      base_d = idx_i & BaseMask;
      off_d  = WrapFirst ? (idx_i[OffW-1:0] & OffMask) : '0;
      beat_d = '0;
    end else if (adv_i) begin
      off_d  = (off_q + 1'b1) & OffMask;
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      off_q  <= '0;
      beat_q <= '0;
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
      beat_q <= beat_d;
    end
  end

  // Address of the beat being loaded this edge, so a fresh start needs no extra cycle.
  assign rd_idx_o = base_d | IdxW'(off_d);
  assign off_o    = off_q;
  assign last_o   = (beat_q == OffMask);

endmodule

// File: rtl/burst_mem_model.sv
// Backing memory that returns a cache line as a latency-delayed, back-pressurable burst.
module burst_mem_model import burst_mem_pkg::*; #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned BURST_LEN  = 2,
  parameter int unsigned LATENCY    = 10,
  parameter bit          WRAP_FIRST = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [31:0]                       req_addr,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [DATA_W-1:0]                 resp_data,
  output logic [off_width(BURST_LEN)-1:0]   resp_word,
  output logic                              resp_last,
  input  logic                              wr_en,
  input  logic [31:0]                       wr_addr,
  input  logic [DATA_W-1:0]                 wr_data
);

  localparam int unsigned IdxW = idx_width(DEPTH);
  localparam int unsigned OffW = off_width(BURST_LEN);
  localparam int unsigned CntW = cnt_width(LATENCY);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic              live_q;
  logic              start, adv, load, last;
  logic [IdxW-1:0]   rd_idx, req_idx, wr_idx;
  logic [OffW-1:0]   off;
  logic              unused_addr_bits;

  assign req_idx = req_addr[IdxW+1:2];
  assign wr_idx  = wr_addr[IdxW+1:2];
  assign unused_addr_bits = ^{req_addr[31:IdxW+2], req_addr[1:0],
                              wr_addr[31:IdxW+2], wr_addr[1:0]};

  // Contents start as mem[i] = i and survive reset.
  logic [DATA_W-1:0] mem [DEPTH];
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
    logic [DATA_W-1:0] word_q = DATA_W'(i);
    always_ff @(posedge clk) begin
      if (wr_en && (wr_idx == IdxW'(i))) word_q <= wr_data;
    end
    assign mem[i] = word_q;
  end

  burst_addr_gen #(
    .IdxW      (IdxW),
    .OffW      (OffW),
    .BurstLen  (BURST_LEN),
    .WrapFirst (WRAP_FIRST)
  ) u_addr_gen (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .adv_i    (adv),
    .idx_i    (req_idx),
    .rd_idx_o (rd_idx),
    .off_o    (off),
    .last_o   (last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start      = 1'b0;
    adv        = 1'b0;
    load       = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = live_q;
        if (req_valid && live_q) begin
          start = 1'b1;
          if (LATENCY == 0) begin
            load    = 1'b1;
            state_d = StBurst;
          end else begin
            cnt_d   = CntW'(LATENCY);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) begin
          load    = 1'b1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          if (last) begin
            state_d = StIdle;
          end else begin
            adv  = 1'b1;
            load = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      if (load) data_q <= mem[rd_idx];
    end
  end

  assign resp_data = data_q;
  assign resp_word = off;
  assign resp_last = resp_valid && last;

endmodule

// File: tb/tb_burst_mem_model.sv
// Scoreboard bench: three configurations (default, no-wrap, zero-latency 4-beat lines).
module tb_burst_mem_model;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  word;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   acc_cyc;

  logic        req_valid [3];
  logic [31:0] req_addr  [3];
  logic        resp_ready[3];
  logic        wr_en     [3];
  logic [31:0] wr_addr   [3];
  logic [31:0] wr_data   [3];
  logic        rr [3];
  logic        rv [3];
  logic        rl [3];
  logic [31:0] rd [3];
  logic        rw_a, rw_b;
  logic [1:0]  rw_c;

  logic [31:0] mdl [3][32];
  beat_t       exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  burst_mem_model u_def (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(rr[0]),
    .req_addr(req_addr[0]), .resp_valid(rv[0]), .resp_ready(resp_ready[0]),
    .resp_data(rd[0]), .resp_word(rw_a), .resp_last(rl[0]), .wr_en(wr_en[0]),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0])
  );

  burst_mem_model #(.WRAP_FIRST(1'b0)) u_nowrap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(rr[1]),
    .req_addr(req_addr[1]), .resp_valid(rv[1]), .resp_ready(resp_ready[1]),
    .resp_data(rd[1]), .resp_word(rw_b), .resp_last(rl[1]), .wr_en(wr_en[1]),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1])
  );

  burst_mem_model #(.LATENCY(0), .BURST_LEN(4)) u_l0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(rr[2]),
    .req_addr(req_addr[2]), .resp_valid(rv[2]), .resp_ready(resp_ready[2]),
    .resp_data(rd[2]), .resp_word(rw_c), .resp_last(rl[2]), .wr_en(wr_en[2]),
    .wr_addr(wr_addr[2]), .wr_data(wr_data[2])
  );

  function automatic logic [31:0] word_of(input int inst);
    if (inst == 0) return {31'd0, rw_a};
    if (inst == 1) return {31'd0, rw_b};
    return {30'd0, rw_c};
  endfunction

  function automatic int bl_of(input int inst);
    return (inst == 2) ? 4 : 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Push the expected beats of a burst using the bench's own memory model.
  task automatic expect_burst(input int inst, input logic [31:0] addr);
    int idx, bl, base, start, off;
    beat_t b;
    bl    = bl_of(inst);
    idx   = int'((addr >> 2) & 32'd31);
    base  = idx & ~(bl - 1);
    start = (inst == 1) ? 0 : (idx & (bl - 1));
    for (int i = 0; i < bl; i++) begin
      off    = (start + i) % bl;
      b.data = mdl[inst][base + off];
      b.word = 2'(off);
      b.last = (i == bl - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_req(input int inst, input logic [31:0] addr);
    logic seen;
    int   guard;
    req_addr[inst]  = addr;
    req_valid[inst] = 1'b1;
    guard = 0;
    do begin
      seen = rr[inst];
      @(posedge clk); #1;
      guard++;
    end while (!seen && guard < 50);
    req_valid[inst] = 1'b0;
    if (!seen) check_eq("req_accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
  endtask

  task automatic write_word(input int inst, input logic [31:0] addr, input logic [31:0] data);
    wr_en[inst]   = 1'b1;
    wr_addr[inst] = addr;
    wr_data[inst] = data;
    @(posedge clk); #1;
    wr_en[inst] = 1'b0;
    mdl[inst][(addr >> 2) & 32'd31] = data;
  endtask

  task automatic collect(input int inst, input int exp_lat, input int stall);
    beat_t e;
    int    guard;
    guard = 0;
    while (!rv[inst] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("first_beat_latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    for (int b = 0; b < bl_of(inst); b++) begin
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", 32'd1, 32'd0);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      check_eq("beat_valid", {31'd0, rv[inst]}, 32'd1);
      check_eq("beat_data", rd[inst], e.data);
      check_eq("beat_word", word_of(inst), {30'd0, e.word});
      check_eq("beat_last", {31'd0, rl[inst]}, {31'd0, e.last});
      if (b == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          check_eq("stall_data", rd[inst], e.data);
          check_eq("stall_word", word_of(inst), {30'd0, e.word});
          check_eq("stall_last", {31'd0, rl[inst]}, {31'd0, e.last});
        end
      end
      resp_ready[inst] = 1'b1;
      @(posedge clk); #1;
      resp_ready[inst] = 1'b0;
    end
    check_eq("ready_after_burst", {31'd0, rr[inst]}, 32'd1);
    check_eq("no_extra_beat", {31'd0, rv[inst]}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, {31'd0, rr[0]}, 32'd0);
    check_eq({tag, "_resp_valid"}, {31'd0, rv[0]}, 32'd0);
    check_eq({tag, "_resp_last"}, {31'd0, rl[0]}, 32'd0);
    check_eq({tag, "_resp_data"}, rd[0], 32'd0);
    check_eq({tag, "_resp_word"}, word_of(0), 32'd0);
  endtask

  task automatic release_and_watch(input string tag);
    logic seen;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_ready_after_release"}, {31'd0, rr[0]}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      seen = seen | rv[0];
    end
    check_eq({tag, "_no_beats_after_reset"}, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int guard;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; resp_ready[k] = 1'b0;
      wr_en[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
      for (int i = 0; i < 32; i++) mdl[k][i] = 32'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_first_release", {31'd0, rr[0]}, 32'd1);

    // Critical word first, default latency.
    expect_burst(0, 32'h0C); send_req(0, 32'h0C); collect(0, 10, 0);
    // Line order from word 0.
    expect_burst(1, 32'h0C); send_req(1, 32'h0C); collect(1, 10, 0);
    // Backpressure on first beat.
    expect_burst(0, 32'h00); send_req(0, 32'h00); collect(0, 10, 3);
    // Preload then read.
    write_word(0, 32'h10, 32'hDEADBEEF);
    expect_burst(0, 32'h10); send_req(0, 32'h10); collect(0, 10, 0);
    // Write to a not-yet-loaded word of the line during WAIT.
    send_req(0, 32'h10);
    write_word(0, 32'h14, 32'hCAFE0005);
    expect_burst(0, 32'h10); collect(0, 10, 0);
    // Zero latency, 4-beat line, address wraps modulo DEPTH.
    expect_burst(2, 32'h84); send_req(2, 32'h84); collect(2, 0, 2);

    // Reset during WAIT.
    send_req(0, 32'h08);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    repeat (2) @(posedge clk);
    #1;
    release_and_watch("rst_wait");
    expect_burst(0, 32'h08); send_req(0, 32'h08); collect(0, 10, 0);

    // Reset mid-BURST, with a request held during reset.
    send_req(0, 32'h18);
    guard = 0;
    while (!rv[0] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    check_eq("mid_burst_valid", {31'd0, rv[0]}, 32'd1);
    rst_n = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    check_reset_outputs("rst_burst");
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    release_and_watch("rst_burst");
    expect_burst(0, 32'h1C); send_req(0, 32'h1C); collect(0, 10, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
